// File: rtl/evaluation_func.sv
// evaluation_func: static board evaluator for a 7x6 connect-four engine.
//
// Splits the board into its 69 four-cell line windows. Each window is
// classified in parallel, then a win check and a signed heuristic sum pick
// the score, which is registered with one cycle of latency.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset, clears o_score
//   i_me_field  mover's pieces,  bit 7*r+c = row r (0 = bottom), column c
//   i_op_field  opponent pieces, same layout
//   o_score     registered signed score, positive favours the mover

// Per-window classifier. Cells set in both fields are blocked and zero out
// the window.
//   me_i/op_i   the four cells of the window
//   win_me_o    all four cells are mine
//   win_op_o    all four cells are the opponent's
//   score_o     signed contribution of this window to the heuristic
module evaluation_func_win #(
  parameter int W3 = 16,
  parameter int W2 = 4,
  parameter int W1 = 1
) (
  input  logic              [3:0]  me_i,
  input  logic              [3:0]  op_i,
  output logic                     win_me_o,
  output logic                     win_op_o,
  output logic signed       [15:0] score_o
);
  logic       blocked;
  logic [2:0] n_me, n_op;

  assign blocked = |(me_i & op_i);
  assign n_me    = 3'($countones(me_i & ~op_i));
  assign n_op    = 3'($countones(op_i & ~me_i));

  function automatic logic signed [15:0] wt(input logic [2:0] k);
    logic signed [15:0] v;
    case (k)
      3'd3:    v = 16'(W3);
      3'd2:    v = 16'(W2);
      3'd1:    v = 16'(W1);
      default: v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    win_me_o = 1'b0;
    win_op_o = 1'b0;
    score_o  = '0;
    if (!blocked) begin
      win_me_o = (n_me == 3'd4);
      win_op_o = (n_op == 3'd4);
      // Only uncontested windows score; wt() gives 0 for k = 0 and k = 4.
      if (n_op == 3'd0)      score_o = wt(n_me);
      else if (n_me == 3'd0) score_o = -wt(n_op);
    end
  end
endmodule

module evaluation_func #(
  parameter int FIELD_SIZE = 42,
  parameter int W_WIN      = 10000,
  parameter int W3         = 16,
  parameter int W2         = 4,
  parameter int W1         = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic        [FIELD_SIZE-1:0] i_me_field,
  input  logic        [FIELD_SIZE-1:0] i_op_field,
  output logic signed [15:0]           o_score
);
  localparam int NWIN = 69;
  localparam logic signed [15:0] WIN_POS = 16'(W_WIN);
  localparam logic signed [15:0] WIN_NEG = -16'(W_WIN);

  // Bit index of cell i (0..3) of window w. Window numbering:
  //   0..23 horizontal, 24..44 vertical, 45..56 up-right, 57..68 up-left.
  function automatic int win_cell(input int w, input int i);
    int v, r, c, idx;
    if (w < 24) begin
      r = w / 4; c = w % 4;
      idx = 7 * r + c + i;
    end else if (w < 45) begin
      v = w - 24; c = v / 3; r = v % 3;
      idx = 7 * (r + i) + c;
    end else if (w < 57) begin
      v = w - 45; r = v / 4; c = v % 4;
      idx = 7 * (r + i) + c + i;
    end else begin
      v = w - 57; r = v / 4; c = 3 + v % 4;
      idx = 7 * (r + i) + c - i;
    end
    return idx;
  endfunction

  logic        [NWIN-1:0] win_me, win_op;
  logic signed [15:0]     win_score [NWIN];
  logic signed [15:0]     sum_d;
  logic signed [15:0]     score_d, score_q;

  for (genvar w = 0; w < NWIN; w++) begin : g_win
    localparam int C0 = win_cell(w, 0);
    localparam int C1 = win_cell(w, 1);
    localparam int C2 = win_cell(w, 2);
    localparam int C3 = win_cell(w, 3);

    evaluation_func_win #(.W3(W3), .W2(W2), .W1(W1)) u_win (
      .me_i     ({i_me_field[C3], i_me_field[C2], i_me_field[C1], i_me_field[C0]}),
      .op_i     ({i_op_field[C3], i_op_field[C2], i_op_field[C1], i_op_field[C0]}),
      .win_me_o (win_me[w]),
      .win_op_o (win_op[w]),
      .score_o  (win_score[w])
    );
  end

  // |sum| <= 69*16, so 16-bit accumulation cannot overflow.
  always_comb begin
    sum_d = '0;
    for (int w = 0; w < NWIN; w++) sum_d = sum_d + win_score[w];
  end

  // Mover's win dominates, including when both sides have a line.
  always_comb begin
    score_d = sum_d;
    if (|win_me)      score_d = WIN_POS;
    else if (|win_op) score_d = WIN_NEG;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) score_q <= '0;
    else          score_q <= score_d;
  end

  assign o_score = score_q;
endmodule

// File: tb/tb_evaluation_func.sv
module tb_evaluation_func;
  logic               clk = 1'b0;
  logic               rst_n;
  logic        [41:0] me, op;
  logic signed [15:0] score;
  int errors = 0;
  int checks = 0;
  int exp_q[$];

  evaluation_func dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_me_field (me),
    .i_op_field (op),
    .o_score    (score)
  );

  always #5 clk = ~clk;

  // Build a board from up to four cell indices; negative index means unused.
  function automatic logic [41:0] cells(input int a, input int b = -1,
                                        input int c = -1, input int d = -1);
    logic [41:0] f;
    f = '0;
    if (a >= 0) f[a] = 1'b1;
    if (b >= 0) f[b] = 1'b1;
    if (c >= 0) f[c] = 1'b1;
    if (d >= 0) f[d] = 1'b1;
    return f;
  endfunction

  // Reference evaluator: walks every start cell in every direction.
  function automatic int model(input logic [41:0] m, input logic [41:0] o);
    int sum, dr, dc, nm, no, nb, rr, cc, idx;
    bit mw, ow;
    sum = 0; mw = 0; ow = 0;
    for (int d = 0; d < 4; d++) begin
      case (d)
        0: begin dr = 0; dc = 1;  end
        1: begin dr = 1; dc = 0;  end
        2: begin dr = 1; dc = 1;  end
        default: begin dr = 1; dc = -1; end
      endcase
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 7; c++) begin
          rr = r + 3 * dr; cc = c + 3 * dc;
          if (rr < 0 || rr > 5 || cc < 0 || cc > 6) continue;
          nm = 0; no = 0; nb = 0;
          for (int i = 0; i < 4; i++) begin
            idx = 7 * (r + i * dr) + (c + i * dc);
            if (m[idx] && o[idx]) nb++;
            else if (m[idx])      nm++;
            else if (o[idx])      no++;
          end
          if (nb != 0) continue;
          if (nm == 4) mw = 1;
          if (no == 4) ow = 1;
          if (no == 0) sum += (nm == 3) ? 16 : (nm == 2) ? 4 : (nm == 1) ? 1 : 0;
          if (nm == 0) sum -= (no == 3) ? 16 : (no == 2) ? 4 : (no == 1) ? 1 : 0;
        end
    end
    if (mw) return 10000;
    if (ow) return -10000;
    return sum;
  endfunction

  // Drive one position, queue its expectation, compare after the next edge.
  task automatic step(input string name, input logic [41:0] m,
                      input logic [41:0] o, input int exp_v);
    logic signed [15:0] ev;
    @(negedge clk);
    me = m; op = o;
    exp_q.push_back(exp_v);
    @(posedge clk); #1;
    ev = 16'(exp_q.pop_front());
    checks++;
    if (score !== ev) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, score, ev);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; me = '0; op = '0;
    #2;
    checks++;
    if (score !== 16'sd0) begin
      errors++;
      $display("FAIL reset_async: got %0d expected 0", score);
    end
    @(negedge clk); rst_n = 1'b1;
    step("reset_empty", '0, '0, 0);
  endtask

  task automatic test_mixed();
    step("pos_a", cells(1, 8), cells(0, 7, 14), -15);
    step("pos_b", cells(1, 8, 15), cells(0, 7, 14), 6);
  endtask

  task automatic test_wins();
    step("op_vert_win", cells(1, 8, 15), cells(0, 7, 14, 21), -10000);
    step("me_horz_win", cells(0, 1, 2, 3), '0, 10000);
    step("win_priority", cells(0, 1, 2, 3), cells(7, 14, 21, 28), 10000);
  endtask

  task automatic test_blocked();
    step("blocked", cells(0), cells(0), 0);
    // Blocked cell kills the op line through it and the me window too.
    step("blocked_line", cells(0, 14), cells(0, 7, 14, 21), model(cells(0, 14), cells(0, 7, 14, 21)));
  endtask

  // Inputs changing between edges must not reach the output.
  task automatic test_hold();
    step("hold_load", cells(1, 8), cells(0, 7, 14), -15);
    me = cells(0, 1, 2, 3);
    #3;
    checks++;
    if (score !== -16'sd15) begin
      errors++;
      $display("FAIL hold: got %0d expected -15", score);
    end
  endtask

  task automatic test_async_reset();
    logic signed [15:0] ev;
    step("arst_pre", cells(1, 8), cells(0, 7, 14), -15);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (score !== 16'sd0) begin
      errors++;
      $display("FAIL arst_mid: got %0d expected 0", score);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(-15);
    @(posedge clk); #1;
    ev = 16'(exp_q.pop_front());
    checks++;
    if (score !== ev) begin
      errors++;
      $display("FAIL arst_reload: got %0d expected %0d", score, ev);
    end
  endtask

  task automatic test_back_to_back();
    logic [41:0] m, o, dm, dop;
    for (int n = 0; n < 60; n++) begin
      dm  = {$urandom, $urandom} & {$urandom, $urandom};
      dop = {$urandom, $urandom} & {$urandom, $urandom};
      m = dm;
      // Mostly legal boards, with an occasional overlap for blocked cells.
      o = (n % 5 == 0) ? dop : (dop & ~dm);
      if (n % 3 == 0) begin
        m = m & {$urandom, $urandom};
        o = o & {$urandom, $urandom};
      end
      step("rand", m, o, model(m, o));
    end
  endtask

  initial begin
    test_reset();
    test_mixed();
    test_wins();
    test_blocked();
    test_hold();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
